// File: rtl/mem_access_ctrl_pkg.sv
// ============================================================================
// Module      : mem_access_ctrl_pkg
// Description : Shared types for the memory access sequencer: FSM states,
//               transaction type codes and the wait-timer width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } txn_e;

  // A disabled timeout (0) still needs a one-bit counter to stay legal.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_ctrl_wait_timer.sv
// ============================================================================
// Module      : wait_timer
// Description : Loadable, saturating up-counter with a terminal flag raised
//               at TIMEOUT-1; the flag never rises when TIMEOUT is 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wait_timer
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CW      = cnt_width(TIMEOUT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic terminal
);

  localparam logic [CW-1:0] c_max = '1;

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= '0;
    end else if (en && (r_count != c_max)) begin
      r_count <= r_count + 1'b1;
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_term
      localparam logic [CW-1:0] c_term = CW'(TIMEOUT - 1);
      assign terminal = (r_count == c_term);
    end else begin : g_no_term
      assign terminal = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module      : mem_access_ctrl
// Description : Single-transaction memory bus sequencer between MAR/MDR and
//               external memory, with ready handshake and wait-state timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          rd_req,
  input  logic          wr_req,
  input  logic [AW-1:0] MAR_out,
  input  logic [DW-1:0] M_bus_out,
  output logic [DW-1:0] M_bus_in,
  output logic          MMD,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  state_e        r_state, w_state_nxt;
  txn_e          r_type,  w_type_nxt;
  logic [AW-1:0] r_addr,  w_addr_nxt;
  logic [DW-1:0] r_wdata, w_wdata_nxt;
  logic [DW-1:0] r_rdata, w_rdata_nxt;
  logic          r_re,    w_re_nxt;
  logic          r_we,    w_we_nxt;
  logic          r_busy,  w_busy_nxt;
  logic          r_done,  w_done_nxt;
  logic          r_mmd,   w_mmd_nxt;
  logic          r_err,   w_err_nxt;

  logic w_tmr_load;
  logic w_tmr_en;
  logic w_tmr_term;

  assign w_tmr_load = (r_state == ADDR);
  assign w_tmr_en   = (r_state == WAIT) && !mem_ready;

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk      (CLK),
    .rst_n    (CLR),
    .load     (w_tmr_load),
    .en       (w_tmr_en),
    .terminal (w_tmr_term)
  );

  // Every output is the registered image of the next-state decode, so the
  // strobes line up with the state they belong to without combinational paths.
  always_comb begin
    w_state_nxt = r_state;
    w_type_nxt  = r_type;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_rdata_nxt = r_rdata;
    w_re_nxt    = r_re;
    w_we_nxt    = r_we;
    w_busy_nxt  = 1'b1;
    w_done_nxt  = 1'b0;
    w_mmd_nxt   = 1'b0;
    w_err_nxt   = r_err;

    unique case (r_state)
      IDLE: begin
        w_busy_nxt = 1'b0;
        w_re_nxt   = 1'b0;
        w_we_nxt   = 1'b0;
        if (rd_req ^ wr_req) begin
          w_state_nxt = ADDR;
          w_type_nxt  = wr_req ? WR : RD;
          w_addr_nxt  = MAR_out;
          if (wr_req) begin
            w_wdata_nxt = M_bus_out;
          end
          w_err_nxt  = 1'b0;
          w_re_nxt   = rd_req;
          w_we_nxt   = wr_req;
          w_busy_nxt = 1'b1;
        end else if (rd_req && wr_req) begin
          w_state_nxt = DONE;
          w_err_nxt   = 1'b1;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end

      ADDR: begin
        w_state_nxt = WAIT;
      end

      WAIT: begin
        if (mem_ready) begin
          w_state_nxt = DONE;
          w_re_nxt    = 1'b0;
          w_we_nxt    = 1'b0;
          w_done_nxt  = 1'b1;
          if (r_type == RD) begin
            w_rdata_nxt = mem_rdata;
            w_mmd_nxt   = 1'b1;
          end
        end else if (w_tmr_term) begin
          w_state_nxt = DONE;
          w_re_nxt    = 1'b0;
          w_we_nxt    = 1'b0;
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
        w_re_nxt    = 1'b0;
        w_we_nxt    = 1'b0;
      end

      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state <= IDLE;
      r_type  <= RD;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_re    <= 1'b0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mmd   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_type  <= w_type_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_rdata <= w_rdata_nxt;
      r_re    <= w_re_nxt;
      r_we    <= w_we_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_mmd   <= w_mmd_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign M_bus_in  = r_rdata;
  assign MMD       = r_mmd;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_re    = r_re;
  assign mem_we    = r_we;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Self-checking bench for mem_access_ctrl; transaction-level
//               model predicts every output per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 4;

  logic          CLK = 1'b0;
  logic          CLR;
  logic          rd_req, wr_req;
  logic [AW-1:0] MAR_out;
  logic [DW-1:0] M_bus_out;
  logic [DW-1:0] M_bus_in;
  logic          MMD, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re, mem_we;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  mem_access_ctrl #(
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TO)
  ) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .MAR_out   (MAR_out),
    .M_bus_out (M_bus_out),
    .M_bus_in  (M_bus_in),
    .MMD       (MMD),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Architectural state visible between transactions.
  logic [DW-1:0] m_rdata;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset;
    m_rdata = '0;
    m_addr  = '0;
    m_wdata = '0;
    m_err   = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".busy"},      32'(busy),      32'd0);
    chk({tag, ".done"},      32'(done),      32'd0);
    chk({tag, ".MMD"},       32'(MMD),       32'd0);
    chk({tag, ".mem_re"},    32'(mem_re),    32'd0);
    chk({tag, ".mem_we"},    32'(mem_we),    32'd0);
    chk({tag, ".err"},       32'(err),       32'(m_err));
    chk({tag, ".mem_addr"},  32'(mem_addr),  32'(m_addr));
    chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(m_wdata));
    chk({tag, ".M_bus_in"},  32'(M_bus_in),  32'(m_rdata));
  endtask

  // kind: 0 read, 1 write, 2 both requests (illegal). nwait = cycles with
  // mem_ready low in WAIT; nwait >= TO means memory never answers.
  task automatic run_txn(input int kind, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                         input int nwait, input bit extra);
    int  done_cyc;
    bit  legal, is_rd, is_wr, tmo, strobe, ready;
    legal = (kind != 2);
    is_rd = (kind == 0);
    is_wr = (kind == 1);
    tmo   = legal && (TO != 0) && (nwait >= TO);
    done_cyc = !legal ? 1 : (tmo ? TO + 2 : nwait + 3);

    rd_req    = (kind != 1);
    wr_req    = (kind != 0);
    MAR_out   = addr;
    M_bus_out = wd;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = 16'($urandom);
    tick;

    if (legal) begin
      m_addr = addr;
      if (is_wr) m_wdata = wd;
      m_err = 1'b0;
    end else begin
      m_err = 1'b1;
    end

    for (int c = 1; c <= done_cyc; c++) begin
      rd_req    = 1'b0;
      wr_req    = 1'b0;
      MAR_out   = 16'($urandom);
      M_bus_out = 16'($urandom);
      if (legal && c >= 2 && c < done_cyc) ready = !tmo && (c == nwait + 2);
      else ready = 1'($urandom_range(0, 1));
      mem_ready = ready;
      mem_rdata = (legal && c >= 2 && c < done_cyc && ready) ? rd : 16'($urandom);
      if (extra && c == 2) begin
        rd_req  = 1'b1;
        MAR_out = addr ^ 16'hFFFF;
      end
      if (extra && c == done_cyc) wr_req = 1'b1;

      if (c == done_cyc && tmo) m_err = 1'b1;
      if (c == done_cyc && legal && !tmo && is_rd) m_rdata = rd;
      strobe = legal && (c < done_cyc);

      chk("busy",      32'(busy),      32'd1);
      chk("mem_re",    32'(mem_re),    32'(strobe && is_rd));
      chk("mem_we",    32'(mem_we),    32'(strobe && is_wr));
      chk("done",      32'(done),      32'(c == done_cyc));
      chk("MMD",       32'(MMD),       32'(c == done_cyc && legal && !tmo && is_rd));
      chk("err",       32'(err),       32'(m_err));
      chk("mem_addr",  32'(mem_addr),  32'(m_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      chk("M_bus_in",  32'(M_bus_in),  32'(m_rdata));
      tick;
    end

    rd_req    = 1'b0;
    wr_req    = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
    check_idle("post");
  endtask

  initial begin
    CLR       = 1'b0;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    MAR_out   = '0;
    M_bus_out = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    model_reset();
    repeat (3) tick;
    check_idle("reset");
    CLR = 1'b1;
    tick;
    check_idle("released");

    // Directed cases
    run_txn(0, 16'h0040, 16'h0000, 16'hBEEF, 0, 1'b0);
    run_txn(1, 16'h0100, 16'h1234, 16'h0000, 3, 1'b0);
    run_txn(0, 16'h0200, 16'h0000, 16'hDEAD, TO, 1'b0);
    run_txn(0, 16'h0300, 16'h0000, 16'hCAFE, 1, 1'b0);
    run_txn(2, 16'h0400, 16'h5555, 16'h0000, 0, 1'b0);
    run_txn(1, 16'h0500, 16'hA5A5, 16'h0000, 0, 1'b0);
    run_txn(0, 16'h0600, 16'h0000, 16'h7777, 2, 1'b1);
    run_txn(1, 16'h0700, 16'h0F0F, 16'h0000, TO - 1, 1'b0);

    // Randomized transactions
    for (int i = 0; i < 30; i++) begin
      int k;
      k = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
      run_txn(k, 16'($urandom), 16'($urandom), 16'($urandom),
              int'($urandom_range(0, TO + 1)), 1'($urandom_range(0, 1)));
    end

    // Reset asserted mid-WAIT
    rd_req  = 1'b1;
    MAR_out = 16'h0800;
    tick;
    rd_req    = 1'b0;
    mem_ready = 1'b0;
    tick;
    tick;
    chk("pre_rst.mem_re", 32'(mem_re), 32'd1);
    chk("pre_rst.busy",   32'(busy),   32'd1);
    CLR = 1'b0;
    #1;
    model_reset();
    chk("rst.mem_re", 32'(mem_re), 32'd0);
    chk("rst.busy",   32'(busy),   32'd0);
    chk("rst.done",   32'(done),   32'd0);
    chk("rst.addr",   32'(mem_addr), 32'd0);
    tick;
    tick;
    CLR = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check_idle("after_rst");
    end
    run_txn(0, 16'h0900, 16'h0000, 16'h4321, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory bus sequencer directly downstream of the datapath's MAR/MDR. It consumes the latched address (MAR_out) and MDR write data (M_bus_out).
- It runs single read or write transactions against external memory with a ready/wait-state handshake.
- It returns read data on M_bus_in, with an MMD strobe so the control unit can load MDR.
- Accesses that never see mem_ready are aborted by a bounded wait-state timer.

Parameters:
- AW, 16, address width (matches MAR).
- DW, 16, data width (matches M bus).
- TIMEOUT, 15, maximum WAIT-state cycles before abort; 0 disables the timeout (wait forever).

Ports:
- CLK  in  1  system clock, rising edge.
- CLR  in  1  reset, asynchronous, active-low.
- rd_req  in  1  single-cycle read request from the control unit.
- wr_req  in  1  single-cycle write request from the control unit.
- MAR_out  in  AW  transaction address from the datapath MAR.
- M_bus_out  in  DW  write data from the MDR, valid in the request cycle.
- M_bus_in  out  DW  read data to the MDR.
- MMD  out  1  one-cycle strobe: load M_bus_in into the MDR.
- busy  out  1  high from the cycle after acceptance until the DONE cycle inclusive.
- done  out  1  one-cycle completion pulse (success or error).
- err  out  1  sticky error flag; cleared when the next request is accepted.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_rdata  in  DW  memory read data, valid when mem_ready=1.
- mem_ready  in  1  memory completion handshake.

Behaviour:
- Reset (CLR=0, asynchronous): state=IDLE; all outputs 0, including M_bus_in, mem_addr, mem_wdata and err; wait counter 0.
- Reset mid-transaction drops mem_re/mem_we immediately, with no done pulse.
- Registered outputs only. No combinational path from mem_ready/mem_rdata to any output.
- IDLE:
  - busy=0.
  - rd_req XOR wr_req: latch MAR_out into mem_addr, latch the type, and (write only) latch M_bus_out into mem_wdata. Clear err; go ADDR.
  - rd_req AND wr_req in the same cycle: no memory access. err=1, go DONE (illegal request).
- ADDR (1 cycle): assert mem_re or mem_we per the latched type; clear counter; go WAIT.
- WAIT:
  - Strobe stays asserted; address and wdata stable.
  - mem_ready=1: read captures mem_rdata into M_bus_in. Go DONE; strobe deasserts entering DONE.
  - mem_ready=0 and counter==TIMEOUT-1 (TIMEOUT≠0): err=1, M_bus_in unchanged, go DONE.
  - Otherwise counter += 1. Counter width is clog2(TIMEOUT+1) and it saturates; it never wraps.
- DONE (1 cycle):
  - done=1; mem_re=mem_we=0.
  - MMD=1 only for a successful read.
  - Go IDLE.
- Latency:
  - Request in cycle 0 → strobe from cycle 1.
  - mem_ready sampled high in cycle 2 at the earliest → done/MMD in cycle 3.
  - Each wait state adds 1 cycle.
  - Timeout: done in cycle TIMEOUT+2.
- Requests while busy=1 are ignored (not queued). A request in the DONE cycle is also ignored. The control unit must wait for done.
- M_bus_in holds the last successfully read word until the next successful read.
- mem_addr/mem_wdata hold their last values between transactions.
- mem_ready outside WAIT is ignored.

Decomposition:
- Shared include mem_ctrl_defs.vh holds:
  - state encodings: IDLE, ADDR, WAIT, DONE (2-bit);
  - transaction type codes: RD, WR.
- One sub-module, wait_timer: loadable, saturating, up-counter with terminal flag; parameterised by TIMEOUT.

Test Plan:
- Reset sequencing: assert CLR=0 mid-WAIT with mem_re=1 → mem_re, busy, done all 0 immediately; after release, IDLE with no done pulse.
- Zero-wait read: rd_req with MAR_out=16'h0040; mem_ready=1 when sampled in cycle 2 with mem_rdata=16'hBEEF → mem_re cycles 1-2; done=MMD=1 in cycle 3 with M_bus_in=16'hBEEF; err=0.
- Write with 3 wait states: wr_req, MAR_out=16'h0100, M_bus_out=16'h1234 → mem_we=1 cycles 1-5 with mem_addr=16'h0100, mem_wdata=16'h1234; done in cycle 6; MMD=0.
- Timeout with TIMEOUT=4 and mem_ready stuck 0 → done=1 and err=1 in cycle 6; MMD=0; M_bus_in unchanged. Next accepted request clears err.
- Simultaneous rd_req=wr_req=1 → no strobe; done=err=1 one cycle later.
- Request while busy: second rd_req during WAIT → ignored; exactly one done pulse; mem_addr unchanged.
